// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer (master) and the PLL / reset side (slave).
// Carries raw lock status in and PLL resets, downstream reset and status out.
interface pll_lock_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [1:0]         lock;
    logic [1:0]         pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  lock,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output retry_count
    );

    modport slave (
        output lock,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  retry_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Brings up a cascaded filter PLL -> system PLL pair: pulses each PLL reset in order, debounces
// each lock, then releases the downstream reset; retries on timeout and restarts on lock loss.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRIES        = 3,
    parameter int RELEASE_DELAY      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pll_lock_sequencer_if.master bus
);
    localparam int RETRY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int MAX_A      = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B      = (LOCK_TIMEOUT > RELEASE_DELAY) ? LOCK_TIMEOUT : RELEASE_DELAY;
    localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST0,
        ST_WAIT0,
        ST_RST1,
        ST_WAIT1,
        ST_RELEASE,
        ST_RUN,
        ST_RETRY,
        ST_FAULT
    } state_t;

    state_t             state;
    logic [1:0]         lock_meta;
    logic [1:0]         lock_s;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   stable_cnt;
    logic [RETRY_W-1:0] retry_count;
    logic [1:0]         pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;

    logic               watch_bit;
    logic               stable_hit;
    logic               timed_out;
    logic               rst_done;
    logic               release_done;

    // NOTE: non-blocking assignments make both stages sample the old value, forming a true 2-FF chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= '0;
            lock_s    <= '0;
        end else begin
            lock_meta <= bus.lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any condition so no latch can be inferred.
        watch_bit = lock_s[0];
        if (state == ST_WAIT1) watch_bit = lock_s[1];
        stable_hit   = watch_bit && (stable_cnt == STABLE_LAST);
        timed_out    = (cycle_cnt == TIMEOUT_LAST);
        rst_done     = (cycle_cnt == RST_LAST);
        release_done = (cycle_cnt == RELEASE_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RST0;
            cycle_cnt   <= '0;
            stable_cnt  <= '0;
            retry_count <= '0;
            pll_rst     <= 2'b11;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);

            case (state)
                ST_RST0: begin
                    if (rst_done) begin
                        state     <= ST_WAIT0;
                        pll_rst   <= 2'b10;
                        cycle_cnt <= '0;
                    end
                end

                ST_WAIT0: begin
                    stable_cnt <= lock_s[0] ? stable_cnt + CNT_W'(1) : '0;
                    if (stable_hit) begin
                        state      <= ST_RST1;
                        cycle_cnt  <= '0;
                        stable_cnt <= '0;
                    end else if (timed_out) begin
                        state      <= ST_RETRY;
                        pll_rst    <= 2'b11;
                        cycle_cnt  <= '0;
                        stable_cnt <= '0;
                    end
                end

                // Stage 0 was locked on entry, so a low lock_s[0] here is a fall.
                ST_RST1: begin
                    if (!lock_s[0]) begin
                        state     <= ST_RETRY;
                        pll_rst   <= 2'b11;
                        cycle_cnt <= '0;
                    end else if (rst_done) begin
                        state     <= ST_WAIT1;
                        pll_rst   <= 2'b00;
                        cycle_cnt <= '0;
                    end
                end

                ST_WAIT1: begin
                    stable_cnt <= lock_s[1] ? stable_cnt + CNT_W'(1) : '0;
                    if (!lock_s[0]) begin
                        state      <= ST_RETRY;
                        pll_rst    <= 2'b11;
                        cycle_cnt  <= '0;
                        stable_cnt <= '0;
                    end else if (stable_hit) begin
                        state      <= ST_RELEASE;
                        cycle_cnt  <= '0;
                        stable_cnt <= '0;
                    end else if (timed_out) begin
                        state      <= ST_RETRY;
                        pll_rst    <= 2'b11;
                        cycle_cnt  <= '0;
                        stable_cnt <= '0;
                    end
                end

                ST_RELEASE: begin
                    if (lock_s != 2'b11) begin
                        state     <= ST_RETRY;
                        pll_rst   <= 2'b11;
                        cycle_cnt <= '0;
                    end else if (release_done) begin
                        state     <= ST_RUN;
                        sys_rst   <= 1'b0;
                        ready     <= 1'b1;
                        cycle_cnt <= '0;
                    end
                end

                // Lock loss while running restarts without consuming a retry; stage 0 wins.
                ST_RUN: begin
                    if (!lock_s[0]) begin
                        state     <= ST_RST0;
                        pll_rst   <= 2'b11;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        cycle_cnt <= '0;
                    end else if (!lock_s[1]) begin
                        state     <= ST_RST1;
                        pll_rst   <= 2'b10;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        cycle_cnt <= '0;
                    end
                end

                ST_RETRY: begin
                    cycle_cnt <= '0;
                    pll_rst   <= 2'b11;
                    if (retry_count < RETRY_MAX) begin
                        retry_count <= retry_count + RETRY_W'(1);
                        state       <= ST_RST0;
                    end else begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end
                end

                ST_FAULT: begin
                    pll_rst <= 2'b11;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                    fault   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pll_rst     = pll_rst;
    assign bus.sys_rst     = sys_rst;
    assign bus.ready       = ready;
    assign bus.fault       = fault;
    assign bus.retry_count = retry_count;
endmodule
